// File: rtl/d16_timer_pkg.sv
// Shared constants for the d16 Wishbone timer: register offsets, CTRL/STATUS layout and
// reset values.
package d16_timer_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_COUNT    = 3'd1;
  localparam logic [2:0] REG_CMP      = 3'd2;
  localparam logic [2:0] REG_STATUS   = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_IE      = 1;
  localparam int unsigned CTRL_RELOAD  = 2;
  localparam int unsigned STATUS_MATCH = 0;
  localparam int unsigned STATUS_OVF   = 1;

  typedef struct packed {
    logic reload;
    logic ie;
    logic en;
  } ctrl_t;

  localparam ctrl_t       CTRL_RESET     = '0;
  localparam logic [15:0] COUNT_RESET    = 16'h0000;
  localparam logic [1:0]  STATUS_RESET   = 2'b00;
  localparam logic [15:0] PRESCALE_RESET = 16'h0000;

endpackage

// File: rtl/d16_wb_timer_if.sv
// Bus signals between the d16 CPU (master) and the timer responder (slave).
// No ack/stall: reads are combinational, writes commit on the clock edge.
interface d16_wb_timer_if;
  logic [15:0] wb_addr;
  logic        wb_cyc;
  logic        wb_we;
  logic [15:0] wb_dat_w;
  logic [15:0] wb_dat_r;
  logic        wb_hit;

  modport master (
    output wb_addr, wb_cyc, wb_we, wb_dat_w,
    input  wb_dat_r, wb_hit
  );

  modport slave (
    input  wb_addr, wb_cyc, wb_we, wb_dat_w,
    output wb_dat_r, wb_hit
  );
endinterface

// File: rtl/d16_timer_prescaler.sv
// Prescaler for the d16 timer: one tick every (divisor+1) enabled cycles.
// Only built when D16_TIMER_PRESCALE_EN is defined.
`ifdef D16_TIMER_PRESCALE_EN
module d16_timer_prescaler (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        restart_i,
  input  logic [15:0] divisor_i,
  output logic        tick_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = en_i && (cnt_q == divisor_i);
    cnt_d  = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? 16'h0000 : cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/d16_wb_timer.sv
// Memory-mapped 16-bit timer on the d16 CPU bus with compare-match/overflow interrupt.
// Optional prescaler register at offset 4 when D16_TIMER_PRESCALE_EN is defined.
module d16_wb_timer
  import d16_timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter logic [15:0] CMP_RESET = 16'hFFFF
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  d16_wb_timer_if.slave  wb,
  output logic           o_int
);

  logic        hit, wr;
  logic [2:0]  off;
  logic        wr_ctrl, wr_count, wr_cmp, wr_status;
  logic        tick;
  logic [15:0] rdata;

  ctrl_t       ctrl_q, ctrl_d;
  logic [15:0] count_q, count_d;
  logic [15:0] cmp_q, cmp_d;
  logic [1:0]  status_q, status_d;

  assign hit       = wb.wb_cyc && (wb.wb_addr[15:3] == BASE_ADDR[15:3]);
  assign off       = wb.wb_addr[2:0];
  assign wr        = hit && wb.wb_we;
  assign wr_ctrl   = wr && (off == REG_CTRL);
  assign wr_count  = wr && (off == REG_COUNT);
  assign wr_cmp    = wr && (off == REG_CMP);
  assign wr_status = wr && (off == REG_STATUS);

`ifdef D16_TIMER_PRESCALE_EN
  logic [15:0] prescale_q;
  logic        wr_prescale, ps_restart;

  assign wr_prescale = wr && (off == REG_PRESCALE);
  // Counter restarts on divisor change and on an EN 0->1 write.
  assign ps_restart  = wr_prescale || (wr_ctrl && wb.wb_dat_w[CTRL_EN] && !ctrl_q.en);

  d16_timer_prescaler u_prescaler (
    .clk_i     (i_clk),
    .rst_ni    (i_reset_n),
    .en_i      (ctrl_q.en),
    .restart_i (ps_restart),
    .divisor_i (prescale_q),
    .tick_o    (tick)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prescale_q <= PRESCALE_RESET;
    end else if (wr_prescale) begin
      prescale_q <= wb.wb_dat_w;
    end
  end
`else
  assign tick = ctrl_q.en;
`endif

  // CPU writes to COUNT/CTRL override the tick update; hardware flag sets override W1C.
  always_comb begin
    logic       match_set, ovf_set;
    logic [1:0] status_clr;
    count_d   = count_q;
    ctrl_d    = ctrl_q;
    cmp_d     = cmp_q;
    match_set = 1'b0;
    ovf_set   = 1'b0;
    if (tick) begin
      if (count_q == cmp_q) begin
        match_set = 1'b1;
        if (ctrl_q.reload) begin
          count_d = '0;
        end else begin
          count_d   = count_q + 16'd1;
          ctrl_d.en = 1'b0;
          ovf_set   = (count_q == 16'hFFFF);
        end
      end else begin
        count_d = count_q + 16'd1;
        ovf_set = (count_q == 16'hFFFF);
      end
    end
    if (wr_count) count_d = wb.wb_dat_w;
    if (wr_ctrl)  ctrl_d  = ctrl_t'(wb.wb_dat_w[2:0]);
    if (wr_cmp)   cmp_d   = wb.wb_dat_w;
    status_clr = wr_status ? wb.wb_dat_w[1:0] : 2'b00;
    status_d   = status_q & ~status_clr;
    if (match_set) status_d[STATUS_MATCH] = 1'b1;
    if (ovf_set)   status_d[STATUS_OVF]   = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ctrl_q   <= CTRL_RESET;
      count_q  <= COUNT_RESET;
      cmp_q    <= CMP_RESET;
      status_q <= STATUS_RESET;
    end else begin
      ctrl_q   <= ctrl_d;
      count_q  <= count_d;
      cmp_q    <= cmp_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      REG_CTRL:     rdata = {13'b0, ctrl_q};
      REG_COUNT:    rdata = count_q;
      REG_CMP:      rdata = cmp_q;
      REG_STATUS:   rdata = {14'b0, status_q};
`ifdef D16_TIMER_PRESCALE_EN
      REG_PRESCALE: rdata = prescale_q;
`else
      REG_PRESCALE: rdata = '0;
`endif
      default:      rdata = '0;
    endcase
  end

  // Zero when not selected so the CPU can OR this with other responders.
  assign wb.wb_dat_r = hit ? rdata : 16'h0000;
  assign wb.wb_hit   = hit;
  assign o_int       = ctrl_q.ie && (|status_q);

endmodule

// File: tb/tb_d16_wb_timer.sv
// Randomized and directed bench for d16_wb_timer against a register-level behavioural model.
// Honours D16_TIMER_PRESCALE_EN the same way as the design.
module tb_d16_wb_timer;

  localparam logic [15:0] BASE = 16'hFF00;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;

  d16_wb_timer_if bus ();

  d16_wb_timer #(
    .BASE_ADDR (BASE),
    .CMP_RESET (16'hFFFF)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .wb        (bus),
    .o_int     (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Behavioural model state
  int m_count, m_cmp, m_pre, m_pcnt;
  bit m_en, m_ie, m_rl, m_match, m_ovf;

  logic [15:0] rd_last;
  logic        hit_last, int_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit in_range(input logic [15:0] a);
    return (int'(a) >= int'(BASE)) && (int'(a) <= int'(BASE) + 7);
  endfunction

  function automatic int m_read(input int off);
    case (off)
      0: return {m_rl, m_ie, m_en};
      1: return m_count;
      2: return m_cmp;
      3: return {m_ovf, m_match};
`ifdef D16_TIMER_PRESCALE_EN
      4: return m_pre;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic m_reset();
    m_count = 0; m_cmp = 16'hFFFF; m_pre = 0; m_pcnt = 0;
    m_en = 0; m_ie = 0; m_rl = 0; m_match = 0; m_ovf = 0;
  endtask

  // One clock edge of the timer, as described by its rules.
  task automatic m_step(input logic [15:0] a, input bit cyc, input bit we, input logic [15:0] d);
    bit wr, tick, set_m, set_o, en_n;
    int off, nxt;
    wr  = cyc && we && in_range(a);
    off = int'(a) - int'(BASE);
`ifdef D16_TIMER_PRESCALE_EN
    tick = m_en && (m_pcnt == m_pre);
`else
    tick = m_en;
`endif
    nxt = m_count; en_n = m_en; set_m = 0; set_o = 0;
    if (tick) begin
      if (m_count == m_cmp) begin
        set_m = 1;
        if (m_rl) nxt = 0;
        else begin
          en_n = 0;
          nxt = (m_count + 1) % 65536;
          set_o = (m_count == 65535);
        end
      end else begin
        nxt = (m_count + 1) % 65536;
        set_o = (m_count == 65535);
      end
    end
`ifdef D16_TIMER_PRESCALE_EN
    if ((wr && off == 4) || (wr && off == 0 && d[0] && !m_en)) m_pcnt = 0;
    else if (m_en) m_pcnt = tick ? 0 : m_pcnt + 1;
`endif
    if (wr && off == 3) begin
      if (d[0]) m_match = 0;
      if (d[1]) m_ovf = 0;
    end
    if (set_m) m_match = 1;
    if (set_o) m_ovf = 1;
    m_en = en_n;
    m_count = nxt;
    if (wr) begin
      case (off)
        0: {m_rl, m_ie, m_en} = d[2:0];
        1: m_count = int'(d);
        2: m_cmp = int'(d);
`ifdef D16_TIMER_PRESCALE_EN
        4: m_pre = int'(d);
`endif
        default: ;
      endcase
    end
  endtask

  task automatic cyc_op(input logic [15:0] a, input bit cyc, input bit we, input logic [15:0] d);
    bit eh;
    @(negedge clk);
    bus.wb_addr = a; bus.wb_cyc = cyc; bus.wb_we = we; bus.wb_dat_w = d;
    #1;
    eh = cyc && in_range(a);
    rd_last = bus.wb_dat_r; hit_last = bus.wb_hit; int_last = irq;
    check("hit", bus.wb_hit, eh);
    check("rdat", bus.wb_dat_r, eh ? m_read(int'(a) - int'(BASE)) : 0);
    check("int", irq, m_ie && (m_match || m_ovf));
    @(posedge clk);
    m_step(a, cyc, we, d);
  endtask

  task automatic wr(input int off, input logic [15:0] d);
    cyc_op(BASE + 16'(off), 1'b1, 1'b1, d);
  endtask

  task automatic rd(input int off);
    cyc_op(BASE + 16'(off), 1'b1, 1'b0, 16'h0000);
  endtask

  task automatic dut_reset();
    @(negedge clk);
    rst_n = 1'b0; bus.wb_cyc = 1'b0; bus.wb_we = 1'b0;
    #1;
    check("rst_int", irq, 0);
    check("rst_hit", bus.wb_hit, 0);
    check("rst_dat", bus.wb_dat_r, 0);
    bus.wb_cyc = 1'b1; bus.wb_addr = BASE + 16'd1;
    #1 check("rst_count", bus.wb_dat_r, 16'h0000);
    bus.wb_addr = BASE + 16'd2;
    #1 check("rst_cmp", bus.wb_dat_r, 16'hFFFF);
    bus.wb_cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  initial begin
    bus.wb_addr = '0; bus.wb_cyc = 1'b0; bus.wb_we = 1'b0; bus.wb_dat_w = '0;
    m_reset();
    dut_reset();

    // Reset taken mid-count
    wr(1, 16'h0120); wr(0, 16'h0003);
    repeat (4) rd(1);
    check("mid_count", rd_last, 16'h0123);
    dut_reset();

    // Decode boundaries
    rd(1);
    check("rd_hit", hit_last, 1);
    check("rd_count0", rd_last, 0);
    cyc_op(BASE + 16'd8, 1'b1, 1'b0, 16'h0000);
    check("above_hit", hit_last, 0);
    check("above_dat", rd_last, 0);
    cyc_op(BASE - 16'd1, 1'b1, 1'b0, 16'h0000);
    check("below_hit", hit_last, 0);

    // Periodic reload with interrupt
    wr(2, 16'h0003); wr(1, 16'h0000); wr(0, 16'h0007);
    for (int j = 0; j < 10; j++) begin
      rd(1);
      check("reload_cnt", rd_last, 16'(j % 4));
      check("reload_int", int_last, (j >= 4) ? 1 : 0);
    end

    // One-shot
    dut_reset();
    wr(2, 16'h0002); wr(0, 16'h0001);
    repeat (6) rd(1);
    check("oneshot_cnt", rd_last, 16'h0003);
    rd(0);
    check("oneshot_ctrl", rd_last, 0);
    rd(3);
    check("oneshot_stat", rd_last, 16'h0001);
    check("oneshot_int", int_last, 0);

    // Overflow and W1C racing a new overflow
    dut_reset();
    wr(2, 16'h0010); wr(1, 16'hFFFF); wr(0, 16'h0001);
    rd(3);
    rd(1);
    check("wrap_cnt", rd_last, 0);
    rd(3);
    check("wrap_ovf", rd_last, 16'h0002);
    wr(1, 16'hFFFF);
    wr(3, 16'h0002);
    rd(3);
    check("w1c_race", rd_last, 16'h0002);
    wr(3, 16'h0002);
    rd(3);
    check("w1c_clear", rd_last, 0);

`ifdef D16_TIMER_PRESCALE_EN
    dut_reset();
    wr(4, 16'h0004); wr(2, 16'h0001); wr(0, 16'h0001);
    for (int j = 0; j < 12; j++) begin
      rd(3);
      check("ps_match", rd_last, (j >= 10) ? 1 : 0);
    end
    rd(1);
    check("ps_count", rd_last, 16'h0002);
`else
    dut_reset();
    wr(4, 16'hFFFF);
    rd(4);
    check("nops_rd", rd_last, 0);
`endif

    // Randomized traffic
    dut_reset();
    for (int i = 0; i < 3000; i++) begin
      int off, sel;
      logic [15:0] a, d;
      bit c, w;
      if (i == 1500) dut_reset();
      off = $urandom_range(0, 9);
      a = (off < 8) ? BASE + 16'(off) : 16'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 6)       d = 16'($urandom_range(0, 7));
      else if (sel < 8)  d = 16'hFFF0 | 16'($urandom_range(0, 15));
      else               d = 16'($urandom);
      if (off == 0 && sel < 8) d = 16'($urandom_range(0, 7));
      if (off == 4)            d = 16'($urandom_range(0, 3));
      c = ($urandom_range(0, 5) != 0);
      w = ($urandom_range(0, 3) == 0);
      cyc_op(a, c, w, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
